// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID latch and a FETCH/WAIT/HALTED sequencer.
// Optional macro FETCH_TIMEOUT_EN adds a wait-cycle watchdog that raises err.
module fetch_stage #(
    parameter logic [15:0] RESET_PC       = 16'h0000,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirectPC,
    input  logic        haltDec,
    output logic [15:0] inst15_0,
    output logic [15:0] incPC,
    output logic        controlMuxSig,
    output logic        instValid,
    output logic        err
);

    localparam logic [15:0] NOP_INST = 16'h0800;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_WAIT   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] inst_q, inst_d;
    logic [15:0] inc_q, inc_d;
    logic        bubble_q, bubble_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [15:0] pc_plus2_s;

`ifdef FETCH_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
`else
    logic        unused_timeout_s;
    assign unused_timeout_s = ^TIMEOUT_CYCLES;
`endif

    assign pc_plus2_s    = pc_q + 16'd2;
    assign imem_req      = (state_q != S_HALTED) && rst && !stall && !redirect;
    assign imem_addr     = pc_q;
    assign inst15_0      = inst_q;
    assign incPC         = inc_q;
    assign controlMuxSig = bubble_q;
    assign instValid     = valid_q;
    assign err           = err_q;

    // Next-state: redirect beats stall, stall beats halt, halt beats memory data.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        inc_d    = inc_q;
        bubble_d = bubble_q;
        valid_d  = valid_q;
        err_d    = err_q;
`ifdef FETCH_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_FETCH, S_WAIT: begin
                if (redirect) begin
                    pc_d     = {redirectPC[15:1], 1'b0};
                    inst_d   = NOP_INST;
                    bubble_d = 1'b1;
                    valid_d  = 1'b0;
                    state_d  = S_FETCH;
                    if (redirectPC[0]) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
`ifdef FETCH_TIMEOUT_EN
                    cnt_d = 16'd0;
`endif
                end else if (stall) begin
                    state_d = state_q;
                end else if (haltDec) begin
                    inst_d   = NOP_INST;
                    bubble_d = 1'b1;
                    valid_d  = 1'b0;
                    state_d  = S_HALTED;
`ifdef FETCH_TIMEOUT_EN
                    cnt_d = 16'd0;
`endif
                end else if (imem_rdy) begin
                    inst_d   = imem_data;
                    inc_d    = pc_plus2_s;
                    pc_d     = pc_plus2_s;
                    bubble_d = 1'b0;
                    valid_d  = 1'b1;
                    state_d  = S_FETCH;
`ifdef FETCH_TIMEOUT_EN
                    cnt_d = 16'd0;
`endif
                end else begin
                    inst_d   = NOP_INST;
                    bubble_d = 1'b1;
                    valid_d  = 1'b0;
                    state_d  = S_WAIT;
`ifdef FETCH_TIMEOUT_EN
                    // Saturate so err stays set and the counter never wraps.
                    if (cnt_q == TIMEOUT_CYCLES) begin
                        cnt_d = cnt_q;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                    if (cnt_d == TIMEOUT_CYCLES) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
`endif
                end
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State, PC and IF/ID registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            inst_q   <= NOP_INST;
            inc_q    <= 16'h0000;
            bubble_q <= 1'b1;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            inc_q    <= inc_d;
            bubble_q <= bubble_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Consecutive wait-cycle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then random traffic vs a reference model.
module tb_fetch_stage;

    localparam logic [15:0] RPC = 16'h0000;
    localparam logic [15:0] TMO = 16'd16;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy;
    logic [15:0] imem_data;
    logic        stall;
    logic        redirect;
    logic [15:0] redirectPC;
    logic        haltDec;
    logic [15:0] inst15_0;
    logic [15:0] incPC;
    logic        controlMuxSig;
    logic        instValid;
    logic        err;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [15:0] m_pc;
    logic [15:0] m_inst;
    logic [15:0] m_inc;
    bit          m_bub;
    bit          m_halt;
    bit          m_err;
    int          m_cnt;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RPC), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdy(imem_rdy), .imem_data(imem_data),
        .stall(stall), .redirect(redirect), .redirectPC(redirectPC),
        .haltDec(haltDec),
        .inst15_0(inst15_0), .incPC(incPC),
        .controlMuxSig(controlMuxSig), .instValid(instValid), .err(err)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc   = RPC;
        m_inst = 16'h0800;
        m_inc  = 16'h0000;
        m_bub  = 1'b1;
        m_halt = 1'b0;
        m_err  = 1'b0;
        m_cnt  = 0;
    endtask

    function automatic bit exp_req();
        return !m_halt && (rst === 1'b1) && !stall && !redirect;
    endfunction

    // Applies the rules of one rising edge to the model.
    task automatic model_edge();
        if (m_halt) begin
            m_halt = 1'b1;
        end else if (redirect) begin
            m_pc   = redirectPC & 16'hFFFE;
            m_inst = 16'h0800;
            m_bub  = 1'b1;
            m_cnt  = 0;
            if (redirectPC % 2 == 1) m_err = 1'b1;
        end else if (stall) begin
            m_cnt = m_cnt;
        end else if (haltDec) begin
            m_halt = 1'b1;
            m_inst = 16'h0800;
            m_bub  = 1'b1;
            m_cnt  = 0;
        end else if (imem_rdy) begin
            m_inst = imem_data;
            m_inc  = 16'((int'(m_pc) + 2) % 65536);
            m_pc   = m_inc;
            m_bub  = 1'b0;
            m_cnt  = 0;
        end else begin
            m_inst = 16'h0800;
            m_bub  = 1'b1;
`ifdef FETCH_TIMEOUT_EN
            if (m_cnt < int'(TMO)) m_cnt++;
            if (m_cnt == int'(TMO)) m_err = 1'b1;
`endif
        end
    endtask

    task automatic check_regs(input string tag);
        check_eq({tag, "_inst"}, inst15_0, m_inst);
        check_eq({tag, "_bub"}, 16'(controlMuxSig), 16'(m_bub));
        check_eq({tag, "_valid"}, 16'(instValid), 16'(!m_bub));
        check_eq({tag, "_err"}, 16'(err), 16'(m_err));
        if (!m_bub) check_eq({tag, "_inc"}, incPC, m_inc);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input string tag, input logic st, input logic rd, input logic [15:0] rpc,
                         input logic hd, input logic rdy, input logic [15:0] data);
        stall = st; redirect = rd; redirectPC = rpc; haltDec = hd;
        imem_rdy = rdy; imem_data = data;
        #1;
        check_eq({tag, "_req"}, 16'(imem_req), 16'(exp_req()));
        check_eq({tag, "_addr"}, imem_addr, m_pc);
        @(posedge clk);
        model_edge();
        #1;
        check_regs(tag);
        @(negedge clk);
    endtask

    // Called at a falling edge; asserts reset mid-cycle, then releases it at a falling edge.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_eq("rst_req", 16'(imem_req), 16'h0000);
        check_eq("rst_addr", imem_addr, RPC);
        check_eq("rst_inc", incPC, 16'h0000);
        check_regs("rst");
        imem_rdy = 1'b1; imem_data = 16'hDEAD; stall = 1'b0; redirect = 1'b0; haltDec = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_regs("rst_hold");
        @(negedge clk);
        rst = 1'b1;
        imem_rdy = 1'b0;
        #1;
        check_eq("rel_req", 16'(imem_req), 16'h0001);
        check_eq("rel_addr", imem_addr, RPC);
    endtask

    initial begin
        rst = 1'b0; imem_rdy = 1'b0; imem_data = 16'h0000;
        stall = 1'b0; redirect = 1'b0; redirectPC = 16'h0000; haltDec = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Back-to-back accepts
        cycle("a0", 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'hC005);
        check_eq("a0_inst_k", inst15_0, 16'hC005);
        check_eq("a0_inc_k", incPC, 16'h0002);
        cycle("a1", 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'hC106);
        check_eq("a1_inst_k", inst15_0, 16'hC106);
        check_eq("a1_inc_k", incPC, 16'h0004);
        check_eq("a1_ctl_k", 16'(controlMuxSig), 16'h0000);

        // Three not-ready cycles then accept
        for (int i = 0; i < 3; i++) begin
            cycle("w", 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h5555);
            check_eq("w_inst_k", inst15_0, 16'h0800);
            check_eq("w_addr_k", imem_addr, 16'h0004);
        end
        cycle("w4", 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h1234);
        check_eq("w4_inc_k", incPC, 16'h0006);

        // PC wrap
        cycle("wr0", 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b1, 16'h9999);
        cycle("wr1", 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'hABCD);
        check_eq("wrap_inc_k", incPC, 16'h0000);
        check_eq("wrap_addr_k", imem_addr, 16'h0000);
        check_eq("wrap_err_k", 16'(err), 16'h0000);

        // Misaligned redirect together with stall
        cycle("mis", 1'b1, 1'b1, 16'h0041, 1'b0, 1'b1, 16'h7777);
        check_eq("mis_addr_k", imem_addr, 16'h0040);
        check_eq("mis_err_k", 16'(err), 16'h0001);
        check_eq("mis_ctl_k", 16'(controlMuxSig), 16'h0001);

        // Halt, ignored redirect, reset restart
        cycle("h0", 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h4444);
        check_eq("halt_req_k", 16'(imem_req), 16'h0000);
        cycle("h1", 1'b0, 1'b1, 16'h0100, 1'b0, 1'b1, 16'h4445);
        check_eq("halt_addr_k", imem_addr, 16'h0040);
        cycle("h2", 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h4446);
        do_reset();
        cycle("hr", 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'hBEEF);
        check_eq("hr_inc_k", incPC, 16'h0002);

        // Memory never ready
        for (int i = 0; i < 15; i++) cycle("t", 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        check_eq("tmo15_err_k", 16'(err), 16'h0000);
        cycle("t16", 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
`ifdef FETCH_TIMEOUT_EN
        check_eq("tmo16_err_k", 16'(err), 16'h0001);
`else
        check_eq("tmo16_err_k", 16'(err), 16'h0000);
`endif
        for (int i = 0; i < 8; i++) cycle("t+", 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);

        // Random traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) < 2) begin
                do_reset();
            end else begin
                logic [15:0] rpc;
                rpc = 16'($urandom()) & 16'hFFFE;
                if ($urandom_range(9) == 0) rpc = rpc | 16'h0001;
                cycle("rnd", 1'($urandom_range(99) < 20), 1'($urandom_range(99) < 10), rpc,
                      1'($urandom_range(99) < 1), 1'($urandom_range(99) < 60), 16'($urandom()));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
